// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product-side and result-side handshakes of mac_accumulator.
// The master drives products, clear and out_ready; the slave (the accumulator) answers.
interface mac_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output prod_valid, prod_data, clear, out_ready,
        input  prod_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  prod_valid, prod_data, clear, out_ready,
        output prod_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_TERMS unsigned products and presents each result via valid/ready.
// Define MAC_ACC_SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
module mac_accumulator #(
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int N_TERMS = 4
) (
    input logic              clk,
    input logic              rst_n,
    mac_accumulator_if.slave bus
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic             live;
    logic [ACC_W-1:0] acc, acc_add;
    logic [ACC_W:0]   sum;
    logic [7:0]       cnt;
    logic             ovf, carry, rdy, accept, last, drain;

    assign sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
    assign carry = sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
    assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    // live holds prod_ready low until the first clock after reset release
    always_comb begin
        rdy           = live && state == ACC;
        accept        = bus.prod_valid && rdy && !bus.clear;
        last          = accept && cnt == 8'(N_TERMS - 1);
        drain         = state == HOLD && bus.out_ready && !bus.clear;
        state_nxt     = bus.clear ? ACC : last ? HOLD : drain ? ACC : state;
        bus.prod_ready = rdy;
        bus.out_valid  = state == HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            bus.out_data <= '0;
            bus.out_ovf  <= 1'b0;
        end else begin
            if (bus.clear || drain) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                acc <= acc_add;
                cnt <= cnt + 8'd1;
                ovf <= ovf | carry;
            end
            if (last) begin
                bus.out_data <= acc_add;
                bus.out_ovf  <= ovf | carry;
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scenarios against mac_accumulator with ACC_W=33, N_TERMS=4.
// Expected overflow result follows MAC_ACC_SATURATE_EN when the bench is built with it.
module tb_mac_accumulator;
    localparam int PW = 32;
    localparam int AW = 33;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW)) bus ();
    mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .N_TERMS(NT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [PW-1:0] d);
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        step();
        bus.prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.prod_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd0) begin errors++; $display("FAIL rst_data: got %0h want 0", bus.out_data); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.out_ovf); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b want 0", bus.prod_ready); end
        step();
        checks++; if (bus.prod_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", bus.prod_ready); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        feed(2); feed(3); feed(4);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
        feed(5);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd14) begin errors++; $display("FAIL basic_data: got %0d want 14", bus.out_data); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", bus.out_ovf); end
        checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b want 0", bus.prod_ready); end
        step();
        checks++; if (bus.prod_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", bus.prod_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        feed(10); feed(20); feed(30); feed(40);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== 33'd100) begin errors++; $display("FAIL bp_data[%0d]: got %0d want 100", i, bus.out_data); end
            checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.prod_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", bus.out_valid); end
        checks++; if (bus.prod_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", bus.prod_ready); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_ovf;
`ifdef MAC_ACC_SATURATE_EN
        exp_ovf = 33'h1_FFFF_FFFF;
`else
        exp_ovf = 33'h1_FFFF_FFFC;
`endif
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(32'hFFFF_FFFF);
        checks++; if (bus.out_data !== exp_ovf) begin errors++; $display("FAIL ovf_data: got %0h want %0h", bus.out_data, exp_ovf); end
        checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.out_ovf); end
        bus.out_ready = 1'b1;
        step();
        feed(2); feed(2); feed(2); feed(2);
        checks++; if (bus.out_data !== 33'd8) begin errors++; $display("FAIL ovf_next_data: got %0d want 8", bus.out_data); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %b want 0", bus.out_ovf); end
        step();
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b0;
        feed(7); feed(8);
        bus.prod_valid = 1'b1;
        bus.prod_data  = 99;
        bus.clear      = 1'b1;
        step();
        bus.clear      = 1'b0;
        bus.prod_valid = 1'b0;
        checks++; if (bus.prod_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", bus.prod_ready); end
        feed(1); feed(1); feed(1); feed(1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd4) begin errors++; $display("FAIL clr_data: got %0d want 4", bus.out_data); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", bus.out_ovf); end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_hold_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd4) begin errors++; $display("FAIL clr_hold_data: got %0d want 4", bus.out_data); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        feed(1); feed(2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_data !== 33'd0) begin errors++; $display("FAIL ar_mid_data: got %0d want 0", bus.out_data); end
        checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL ar_mid_ready: got %b want 0", bus.prod_ready); end
        #1 rst_n = 1'b1;
        step();
        feed(1); feed(2); feed(3); feed(4);
        checks++; if (bus.out_data !== 33'd10) begin errors++; $display("FAIL ar_sum: got %0d want 10", bus.out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_hold_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd0) begin errors++; $display("FAIL ar_hold_data: got %0d want 0", bus.out_data); end
        #1 rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        feed(1); feed(2); feed(3); feed(4);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_after_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd10) begin errors++; $display("FAIL ar_after_data: got %0d want 10", bus.out_data); end
        step();
    endtask

    task automatic test_gapped();
        logic [PW-1:0] v [4];
        v = '{32'd6, 32'd0, 32'd9, 32'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            feed(v[i]);
            if (i < 3) begin
                bus.prod_data = 32'hDEAD;
                step();
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d]: got %b want 0", i, bus.out_valid); end
            end
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 33'd16) begin errors++; $display("FAIL gap_data: got %0d want 16", bus.out_data); end
        step();
    endtask

    initial begin
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.clear      = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_async_reset();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
